// File: rtl/accel_spi_sequencer.sv
// accel_spi_sequencer
//   Transaction sequencer for the ADXL362 accelerometer SPI link. Owns chip
//   select and drives a byte-level SPI engine through a start/done handshake.
//   After reset it writes POWER_CTL = measure, then periodically burst-reads
//   the Y and Z axes and publishes them with a one-cycle valid strobe.
//
// Ports
//   clk_i           system clock
//   reset_i         synchronous, active-high reset
//   enable_i        allows periodic reads (configuration runs regardless)
//   byte_busy_i     SPI engine is shifting a byte
//   byte_done_i     one-cycle pulse, rx_byte_i valid this cycle
//   rx_byte_i       byte received from MISO
//   byte_start_o    one-cycle pulse, engine shifts tx_byte_o
//   tx_byte_o       byte to send on MOSI
//   cs_n_o          accelerometer chip select, active low
//   accel_y_o       last Y sample
//   accel_z_o       last Z sample
//   sample_valid_o  one-cycle pulse when accel_y_o/accel_z_o update
//   configured_o    high once the POWER_CTL write has completed
//   timeout_err_o   sticky; cleared by the next good sample or reset
//
// state       | meaning
// GAP         | cs_n high, CS_GAP cycles between transactions
// PERIOD_WAIT | cs_n high, waiting for sample period and enable
// CS_SETUP    | cs_n low, CS_GAP cycles before the first byte
// XFER        | waiting for engine idle, then issue one byte
// XFER_WAIT   | waiting for byte_done, or timeout
// CS_HOLD     | cs_n low, CS_GAP cycles after the last byte
module accel_spi_sequencer #(
    parameter int unsigned SAMPLE_PERIOD  = 1_000_000,
    parameter int unsigned CS_GAP         = 20,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       byte_busy_i,
    input  logic       byte_done_i,
    input  logic [7:0] rx_byte_i,
    output logic       byte_start_o,
    output logic [7:0] tx_byte_o,
    output logic       cs_n_o,
    output logic [7:0] accel_y_o,
    output logic [7:0] accel_z_o,
    output logic       sample_valid_o,
    output logic       configured_o,
    output logic       timeout_err_o
);

    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(CS_GAP - 1);
    localparam logic [TO_W-1:0]  TO_LOAD    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0]      PERIOD_MAX = 24'(SAMPLE_PERIOD - 1);
    // Leaving PERIOD_WAIT is followed by CS setup plus one XFER cycle before
    // byte 0 is issued; the exit threshold is pulled in by that fixed lead so
    // consecutive byte-0 starts land exactly SAMPLE_PERIOD cycles apart.
    localparam int unsigned      START_LEAD = CS_GAP + 1;
    localparam logic [23:0]      PERIOD_GO  = (SAMPLE_PERIOD - 1 >= START_LEAD) ?
                                              24'(SAMPLE_PERIOD - 1 - START_LEAD) : 24'd0;

    typedef enum logic {MODE_CONFIG, MODE_READ} mode_t;
    typedef enum logic [2:0] {
        ST_GAP, ST_PERIOD_WAIT, ST_CS_SETUP, ST_XFER, ST_XFER_WAIT, ST_CS_HOLD
    } state_t;

    state_t           state_q;
    mode_t            mode_q;
    logic [1:0]       idx_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [23:0]      period_cnt_q, period_cnt_d;
    logic [7:0]       y_cap_q, z_cap_q;
    logic [7:0]       tx_byte_q, accel_y_q, accel_z_q;
    logic             byte_start_q, cs_n_q, sample_valid_q, configured_q, timeout_err_q;
    logic [7:0]       seq_byte_d;
    logic             last_byte_d;

    always_comb begin
        seq_byte_d = 8'h00;
        if (mode_q == MODE_CONFIG) begin
            case (idx_q)
                2'd0:    seq_byte_d = 8'h0A;
                2'd1:    seq_byte_d = 8'h2D;
                default: seq_byte_d = 8'h02;
            endcase
        end else begin
            case (idx_q)
                2'd0:    seq_byte_d = 8'h0B;
                2'd1:    seq_byte_d = 8'h09;
                default: seq_byte_d = 8'h00;
            endcase
        end
        last_byte_d  = (mode_q == MODE_CONFIG) ? (idx_q == 2'd2) : (idx_q == 2'd3);
        period_cnt_d = (period_cnt_q >= PERIOD_MAX) ? PERIOD_MAX : period_cnt_q + 24'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_GAP;
            mode_q         <= MODE_CONFIG;
            idx_q          <= 2'd0;
            gap_cnt_q      <= GAP_LOAD;
            to_cnt_q       <= TO_LOAD;
            period_cnt_q   <= 24'd0;
            y_cap_q        <= 8'h00;
            z_cap_q        <= 8'h00;
            tx_byte_q      <= 8'h00;
            accel_y_q      <= 8'h00;
            accel_z_q      <= 8'h00;
            byte_start_q   <= 1'b0;
            cs_n_q         <= 1'b1;
            sample_valid_q <= 1'b0;
            configured_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            byte_start_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            period_cnt_q   <= period_cnt_d;
            case (state_q)
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        gap_cnt_q <= GAP_LOAD;
                        idx_q     <= 2'd0;
                        if (mode_q == MODE_CONFIG) begin
                            cs_n_q  <= 1'b0;
                            state_q <= ST_CS_SETUP;
                        end else begin
                            state_q <= ST_PERIOD_WAIT;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                ST_PERIOD_WAIT: begin
                    if (period_cnt_q >= PERIOD_GO && enable_i) begin
                        mode_q    <= MODE_READ;
                        idx_q     <= 2'd0;
                        gap_cnt_q <= GAP_LOAD;
                        cs_n_q    <= 1'b0;
                        state_q   <= ST_CS_SETUP;
                    end
                end
                ST_CS_SETUP: begin
                    if (gap_cnt_q == '0) state_q <= ST_XFER;
                    else gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                end
                ST_XFER: begin
                    if (!byte_busy_i) begin
                        tx_byte_q    <= seq_byte_d;
                        byte_start_q <= 1'b1;
                        to_cnt_q     <= TO_LOAD;
                        state_q      <= ST_XFER_WAIT;
                        if (mode_q == MODE_READ && idx_q == 2'd0) period_cnt_q <= 24'd0;
                    end
                end
                ST_XFER_WAIT: begin
                    // byte_done takes priority over a timeout on the same cycle
                    if (byte_done_i) begin
                        if (mode_q == MODE_READ && idx_q == 2'd2) y_cap_q <= rx_byte_i;
                        if (mode_q == MODE_READ && idx_q == 2'd3) z_cap_q <= rx_byte_i;
                        if (last_byte_d) begin
                            gap_cnt_q <= GAP_LOAD;
                            state_q   <= ST_CS_HOLD;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= ST_XFER;
                        end
                    end else if (to_cnt_q == '0) begin
                        cs_n_q        <= 1'b1;
                        timeout_err_q <= 1'b1;
                        configured_q  <= 1'b0;
                        mode_q        <= MODE_CONFIG;
                        gap_cnt_q     <= GAP_LOAD;
                        state_q       <= ST_GAP;
                    end else begin
                        to_cnt_q <= to_cnt_q - TO_W'(1);
                    end
                end
                ST_CS_HOLD: begin
                    if (gap_cnt_q == '0) begin
                        cs_n_q    <= 1'b1;
                        gap_cnt_q <= GAP_LOAD;
                        state_q   <= ST_GAP;
                        if (mode_q == MODE_CONFIG) begin
                            configured_q <= 1'b1;
                            mode_q       <= MODE_READ;
                        end else begin
                            accel_y_q      <= y_cap_q;
                            accel_z_q      <= z_cap_q;
                            sample_valid_q <= 1'b1;
                            timeout_err_q  <= 1'b0;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                default: state_q <= ST_GAP;
            endcase
        end
    end

    assign byte_start_o   = byte_start_q;
    assign tx_byte_o      = tx_byte_q;
    assign cs_n_o         = cs_n_q;
    assign accel_y_o      = accel_y_q;
    assign accel_z_o      = accel_z_q;
    assign sample_valid_o = sample_valid_q;
    assign configured_o   = configured_q;
    assign timeout_err_o  = timeout_err_q;

endmodule
